// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl
// ----------------------------------------------------------------------------
// Built-in self-test controller for the c17 combinational benchmark core.
// A run is launched with `start`. A 5-bit maximal LFSR supplies one pattern
// per clock on `pi`. The c17 responses on `po` are folded into an 8-bit MISR.
// After PATTERN_COUNT patterns the signature is compared with GOLDEN_SIG, and
// the result is held in DONE.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (overrides everything)
//   start        launch a run (honoured in IDLE and DONE)
//   abort        cancel a run (honoured in RUN only; wins over start)
//   pi[4:0]      to c17: N1,N2,N3,N6,N7 (MSB..LSB); zero outside RUN
//   po[1:0]      from c17: N22,N23; sampled in the same cycle pi is shown
//   busy         high in RUN and COMPARE
//   done         high in DONE
//   pass         signature == GOLDEN_SIG; valid while done=1
//   signature    current MISR contents
//   pattern_idx  index of the pattern currently on pi
//   fsm_state    debug view of the controller state (IDLE=0,RUN=1,COMPARE=2,DONE=3)
//
// Handshake: start and abort are level-sampled request strobes. They are
// acted on at the rising edge only in the states listed above. done/pass is a
// sticky status that remains until the next start or rst.
module c17_bist_ctrl #(
   parameter int unsigned PATTERN_COUNT = 31,
   parameter logic [4:0]  LFSR_SEED     = 5'b00001,
   parameter logic [7:0]  MISR_SEED     = 8'h00,
   parameter logic [7:0]  GOLDEN_SIG    = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [4:0] pi,
   input  logic [1:0] po,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] signature,
   output logic [7:0] pattern_idx,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [4:0] SEED_EFF = (LFSR_SEED == 5'b00000) ? 5'b00001 : LFSR_SEED;
   localparam logic [7:0] LAST_IDX = 8'(PATTERN_COUNT - 1);

   state_t     state_q, state_d;
   logic [4:0] lfsr_q, lfsr_d;
   logic [7:0] misr_q, misr_d;
   logic [7:0] idx_q, idx_d;
   logic       pass_q, pass_d;

   logic [4:0] lfsr_next;
   logic [7:0] misr_next;
   logic       misr_fb;

   // x^5 + x^3 + 1, period 31
   assign lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

   // The MISR shifts left with feedback, and po is XORed into the two low bits.
   assign misr_fb   = misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3];
   assign misr_next = {misr_q[6:0], misr_fb} ^ {6'b0, po};

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lfsr_d  = SEED_EFF;
               misr_d  = MISR_SEED;
               idx_d   = 8'd0;
               pass_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               // The MISR is left untouched on the abort edge.
               pass_d  = 1'b0;
               state_d = IDLE;
            end else begin
               misr_d = misr_next;
               idx_d  = idx_q + 8'd1;
               if (idx_q == LAST_IDX) begin
                  // The LFSR holds after the last pattern. pi is zero from here on.
                  state_d = COMPARE;
               end else begin
                  lfsr_d = lfsr_next;
               end
            end
         end
         COMPARE: begin
            pass_d  = (misr_q == GOLDEN_SIG);
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_EFF;
         misr_q  <= MISR_SEED;
         idx_q   <= 8'd0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
      end
   end

   assign pi          = (state_q == RUN) ? lfsr_q : 5'b00000;
   assign busy        = (state_q == RUN) || (state_q == COMPARE);
   assign done        = (state_q == DONE);
   assign pass        = pass_q;
   assign signature   = misr_q;
   assign pattern_idx = idx_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Testbench for c17_bist_ctrl. Three controller instances are used, each with
// its own c17 model:
//   0: PATTERN_COUNT=1,  GOLDEN_SIG=8'h01
//   1: PATTERN_COUNT=2,  GOLDEN_SIG=8'h01
//   2: PATTERN_COUNT=31, LFSR_SEED=0, GOLDEN_SIG=8'h00
// `sel` selects which instance the generic tasks drive and observe.
module tb_c17_bist_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start_v [3];
   logic       abort_v [3];
   logic [4:0] pi_a    [3];
   logic [1:0] po_a    [3];
   logic       busy_a  [3];
   logic       done_a  [3];
   logic       pass_a  [3];
   logic [7:0] sig_a   [3];
   logic [7:0] idx_a   [3];
   logic [1:0] st_a    [3];

   int tests_run = 0;
   int tests_failed = 0;
   int sel;

   // Reference c17 netlist: six NAND gates.
   function automatic logic [1:0] c17_f(input logic [4:0] p);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
      n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      n22 = ~(n10 & n16);
      n23 = ~(n16 & n19);
      return {n22, n23};
   endfunction

   function automatic logic [4:0] lfsr_step(input logic [4:0] l);
      return {l[3:0], l[4] ^ l[2]};
   endfunction

   function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [1:0] p);
      return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {6'b0, p};
   endfunction

   assign po_a[0] = c17_f(pi_a[0]);
   assign po_a[1] = c17_f(pi_a[1]);
   assign po_a[2] = c17_f(pi_a[2]);

   c17_bist_ctrl #(.PATTERN_COUNT(1), .LFSR_SEED(5'b00001), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h01)) u_p1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .pi(pi_a[0]), .po(po_a[0]),
      .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .signature(sig_a[0]),
      .pattern_idx(idx_a[0]), .fsm_state(st_a[0]));

   c17_bist_ctrl #(.PATTERN_COUNT(2), .LFSR_SEED(5'b00001), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h01)) u_p2 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .pi(pi_a[1]), .po(po_a[1]),
      .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .signature(sig_a[1]),
      .pattern_idx(idx_a[1]), .fsm_state(st_a[1]));

   c17_bist_ctrl #(.PATTERN_COUNT(31), .LFSR_SEED(5'b00000), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h00)) u_p31 (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .pi(pi_a[2]), .po(po_a[2]),
      .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .signature(sig_a[2]),
      .pattern_idx(idx_a[2]), .fsm_state(st_a[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pi"},   32'(pi_a[sel]),   32'h0);
      check({tag, "_busy"}, 32'(busy_a[sel]), 32'h0);
      check({tag, "_done"}, 32'(done_a[sel]), 32'h0);
      check({tag, "_pass"}, 32'(pass_a[sel]), 32'h0);
      check({tag, "_sig"},  32'(sig_a[sel]),  32'h00);
      check({tag, "_idx"},  32'(idx_a[sel]),  32'h0);
   endtask

   // Full run on instance `sel`, checked against the bench's LFSR/MISR/c17 model.
   // Returns the model signature and verifies latency, pi sequence and pass.
   task automatic run_check(input int pc, input logic [4:0] seed, input logic [7:0] golden,
                            input string tag, output logic [7:0] sig_out);
      logic [4:0] ml;
      logic [7:0] ms;
      logic [31:0] seen;
      int edges;
      ml = (seed == 5'b0) ? 5'b00001 : seed;
      ms = 8'h00;
      seen = 32'h0;
      start_v[sel] = 1'b1;
      tick();
      start_v[sel] = 1'b0;
      edges = 1;
      check({tag, "_done_drop"}, 32'(done_a[sel]), 32'h0);
      check({tag, "_busy_run"},  32'(busy_a[sel]), 32'h1);
      for (int k = 0; k < pc; k++) begin
         check({tag, "_pi"},  32'(pi_a[sel]),  32'(ml));
         check({tag, "_idx"}, 32'(idx_a[sel]), 32'(k));
         seen[pi_a[sel]] = 1'b1;
         ms = misr_step(ms, c17_f(ml));
         ml = lfsr_step(ml);
         tick();
         edges++;
      end
      check({tag, "_cmp_busy"}, 32'(busy_a[sel]), 32'h1);
      check({tag, "_cmp_pi"},   32'(pi_a[sel]),   32'h0);
      while (!done_a[sel] && edges < pc + 10) begin
         tick();
         edges++;
      end
      check({tag, "_latency"}, 32'(edges), 32'(pc + 2));
      check({tag, "_done"},    32'(done_a[sel]), 32'h1);
      check({tag, "_busy_end"}, 32'(busy_a[sel]), 32'h0);
      check({tag, "_sig"},     32'(sig_a[sel]),  32'(ms));
      check({tag, "_pass"},    32'(pass_a[sel]), 32'(ms == golden));
      if (pc == 31) check({tag, "_all31"}, seen, 32'hFFFF_FFFE);
      sig_out = ms;
   endtask

   task automatic step_to_idx(input int target, input string tag);
      int n;
      n = 0;
      while (idx_a[sel] != 8'(target) && n < 64) begin
         tick();
         n++;
      end
      check({tag, "_reach_idx"}, 32'(idx_a[sel]), 32'(target));
   endtask

   logic [4:0] first_pi [6];
   logic [7:0] sig1, sig2, full_sig, sig_tmp;

   initial begin
      first_pi[0] = 5'b00001; first_pi[1] = 5'b00010; first_pi[2] = 5'b00100;
      first_pi[3] = 5'b01001; first_pi[4] = 5'b10010; first_pi[5] = 5'b00101;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         abort_v[i] = 1'b0;
      end

      // Reset: two cycles of rst followed by three idle cycles.
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         check_reset_vals("reset");
      end

      // One pattern: pi=00001, po=01, signature 01, pass expected.
      sel = 0;
      run_check(1, 5'b00001, 8'h01, "p1", sig1);
      check("p1_sig_hand",  32'(sig_a[0]),  32'h01);
      check("p1_pass_hand", 32'(pass_a[0]), 32'h1);

      // Two patterns: 00001 then 00010, signature 02, so pass is 0 against golden 01.
      sel = 1;
      run_check(2, 5'b00001, 8'h01, "p2", sig2);
      check("p2_sig_hand",  32'(sig_a[1]),  32'h02);
      check("p2_pass_hand", 32'(pass_a[1]), 32'h0);

      // Full run with a zero seed; the first six patterns are hand-computed.
      sel = 2;
      start_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("p31_first_pi", 32'(pi_a[2]), 32'(first_pi[k]));
         tick();
      end
      // Let this run finish, then perform a fresh checked run from DONE.
      for (int n = 0; n < 40 && !done_a[2]; n++) tick();
      check("p31_first_done", 32'(done_a[2]), 32'h1);
      run_check(31, 5'b00000, 8'h00, "p31", full_sig);

      // Abort at pattern 5. A simultaneous start must lose to abort.
      start_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      step_to_idx(5, "abort");
      sig_tmp = sig_a[2];
      abort_v[2] = 1'b1;
      start_v[2] = 1'b1;
      tick();
      abort_v[2] = 1'b0;
      start_v[2] = 1'b0;
      check("abort_state", 32'(st_a[2]),   32'h0);
      check("abort_done",  32'(done_a[2]), 32'h0);
      check("abort_busy",  32'(busy_a[2]), 32'h0);
      check("abort_pi",    32'(pi_a[2]),   32'h0);
      check("abort_pass",  32'(pass_a[2]), 32'h0);
      check("abort_sig_hold", 32'(sig_a[2]), 32'(sig_tmp));
      tick();
      check("abort_stays_idle", 32'(st_a[2]), 32'h0);
      run_check(31, 5'b00000, 8'h00, "restart", sig_tmp);
      check("restart_same_sig", 32'(sig_a[2]), 32'(full_sig));

      // Reset in the middle of a run (pattern 10).
      start_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      step_to_idx(10, "midrst");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
      check("midrst_state", 32'(st_a[2]), 32'h0);

      // Run to DONE, then restart directly from DONE.
      run_check(31, 5'b00000, 8'h00, "after_rst", sig_tmp);
      run_check(31, 5'b00000, 8'h00, "from_done", sig_tmp);
      check("from_done_same_sig", 32'(sig_a[2]), 32'(full_sig));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog: stop the run if the directed sequence stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
